arm_register_file: RTL and testbench
====================================

# arm_register_file

16 × 32-bit ARM general-purpose register file with R15 acting as the program counter. It sits directly downstream of the 4-to-16 write-address decoder: it consumes the decoder's 16-bit one-hot write-enable vector and stores write-back data into the selected register. It provides three combinational read ports (Rn, Rm, Rs/Rd-for-store) to the datapath. It also maintains the PC with load and auto-increment paths.

## Interface
- `DATA_WIDTH`, 32, register and data width.
- `PC_RESET`, 32'h0000_0000, PC value after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `wr_en` input 16: one-hot write-enable vector from the address decoder; all-zero means no write.
- `wr_data` input DATA_WIDTH: write-back data.
- `pc_load` input 1: load PC from `pc_data` (branch).
- `pc_data` input DATA_WIDTH: branch target.
- `pc_inc` input 1: advance PC by 4.
- `rd_addr_a`, `rd_addr_b`, `rd_addr_c` input 4 each: read addresses.
- `rd_data_a`, `rd_data_b`, `rd_data_c` output DATA_WIDTH each: read data.
- `pc_out` output DATA_WIDTH: current PC, used for instruction fetch.
- `wr_err` output 1: sticky flag, set when `wr_en` has more than one bit set.

## Operation
- Registers R0–R14 are written when `wr_en[i]` = 1. The register takes `wr_data` at the next rising edge.
- R15 (the PC) is updated by a priority chain, evaluated each cycle:
  - `pc_load` → `pc_data`
  - else `wr_en[15]` → `wr_data`
  - else `pc_inc` → PC + 4
  - else hold.
- PC arithmetic is modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of the PC are stored exactly as written and are not forced to zero.
- Read ports are purely combinational from the stored registers:
  - Address 0–14 returns the register contents.
  - Address 15 returns PC + 8, modulo 2^DATA_WIDTH, matching ARM pipeline semantics.
- There is no write-to-read bypass. A value written at edge N is visible on the read ports only after edge N.
- Multi-hot `wr_en` (popcount > 1): that cycle's register write is suppressed entirely, including R15 via `wr_en[15]`.
  - `wr_err` is set at the next edge and stays set until reset.
  - `pc_load` and `pc_inc` still act normally in that cycle.
- `pc_out` shows the raw PC, without the +8 offset.

## Timing
- Reset (synchronous, `reset` = 1 at a rising edge):
  - R0–R14 ← 0, PC ← `PC_RESET`, `wr_err` ← 0.
  - After the reset edge, `rd_data_*` show 0 for R0–R14 and `PC_RESET` + 8 for R15; `pc_out` = `PC_RESET`.
- Reset has priority over every write, load and increment in the same cycle. Reset asserted in the middle of a sequence of writes discards the pending write.
- Write latency: 1 cycle, from inputs sampled at edge N to the new value visible after edge N.
- Read latency: 0 cycles (combinational from address to data).
- Simultaneous `pc_load` and `wr_en[15]`: `pc_load` wins and `wr_data` is discarded.
- Simultaneous `wr_en[15]` and `pc_inc`: the write wins; no increment happens that cycle.
- The same register read on all three ports returns identical data.
- Any `rd_addr` value is legal. All 16 addresses are decoded, so no X state is possible.

## Structure
- Shared package `arm_rf_pkg` holds:
  - `NUM_REGS` = 16
  - `PC_INDEX` = 15
  - `PC_STEP` = 4
  - `PC_READ_OFFSET` = 8
  - typedef `reg_word_t` (DATA_WIDTH-bit word)
  - typedef `reg_sel_t` (4-bit address)
- Sub-module `rf_read_port`: a 16:1 mux with the R15 +8 adjustment. It is instantiated three times.
- Register storage, the PC priority logic and the popcount/error logic live in the top module.

## Test plan
- **Reset:** `reset` = 1 for one edge with `PC_RESET` = 32'h100 → `pc_out` = 32'h100, `rd_data_a` at address 15 = 32'h108, R3 reads 0, `wr_err` = 0.
- **Basic write:** `wr_en` = 16'h0008, `wr_data` = 32'hDEAD_BEEF at one edge → R3 reads 32'hDEAD_BEEF on all three ports afterwards; other registers are unchanged. Reading R3 in the same cycle as the write still returns the old value.
- **PC priority:** `pc_load` = 1 with `pc_data` = 32'h2000, `wr_en` = 16'h8000 with `wr_data` = 32'h3000, and `pc_inc` = 1, all in one cycle → `pc_out` = 32'h2000. Next cycle `pc_inc` only → 32'h2004.
- **PC wrap:** PC loaded to 32'hFFFF_FFFC, then `pc_inc` → `pc_out` = 0. Before the increment, reading R15 returns 32'h0000_0004 (wrapped +8).
- **Multi-hot:** `wr_en` = 16'h0006, `wr_data` = 32'h55 → R1 and R2 are unchanged and `wr_err` = 1. After a later valid write, `wr_err` is still 1; it clears only on `reset`.
- **Reset mid-write:** `reset` = 1 together with `wr_en` = 16'h0010 and `wr_data` = 32'hAA → R4 = 0 after the edge.

Source files
------------

// File: rtl/arm_rf_pkg.sv
// arm_rf_pkg: shared constants and types for the ARM register file
package arm_rf_pkg;
  localparam int NUM_REGS = 16;
  localparam int PC_INDEX = 15;
  localparam int PC_STEP = 4;
  localparam int PC_READ_OFFSET = 8;
  typedef logic [31:0] reg_word_t;
  typedef logic [3:0] reg_sel_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: 16:1 register read mux returning PC+8 for R15
module rf_read_port
  import arm_rf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  reg_sel_t              addr,
  output logic [DATA_WIDTH-1:0] data
);
  always_comb data = addr == reg_sel_t'(PC_INDEX) ? regs[addr] + DATA_WIDTH'(PC_READ_OFFSET) : regs[addr];
endmodule

// File: rtl/arm_register_file.sv
// arm_register_file: 16x32 ARM register file with R15 as PC, three read ports
module arm_register_file
  import arm_rf_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pc_load,
  input  logic [DATA_WIDTH-1:0] pc_data,
  input  logic                  pc_inc,
  input  reg_sel_t              rd_addr_a,
  input  reg_sel_t              rd_addr_b,
  input  reg_sel_t              rd_addr_c,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  wr_err
);
  logic [DATA_WIDTH-1:0] gpr [PC_INDEX];
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic multi;
  assign multi = (wr_en & (wr_en - 16'd1)) != 16'd0;
  always_comb pc_next = pc_load ? pc_data : (wr_en[PC_INDEX] && !multi) ? wr_data : pc_inc ? pc + DATA_WIDTH'(PC_STEP) : pc;
  always_ff @(posedge clk) begin
    for (int k = 0; k < PC_INDEX; k++) gpr[k] <= reset ? '0 : (wr_en[k] && !multi) ? wr_data : gpr[k];
    pc <= reset ? PC_RESET : pc_next;
    wr_err <= !reset && (wr_err || multi);
  end
  for (genvar i = 0; i < PC_INDEX; i++) begin : g_regs
    assign regs[i] = gpr[i];
  end
  assign regs[PC_INDEX] = pc;
  assign pc_out = pc;
  rf_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (.regs(regs), .addr(rd_addr_a), .data(rd_data_a));
  rf_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (.regs(regs), .addr(rd_addr_b), .data(rd_data_b));
  rf_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_c (.regs(regs), .addr(rd_addr_c), .data(rd_data_c));
endmodule

// File: tb/tb_arm_register_file.sv
// tb_arm_register_file: directed test plan plus random traffic against a reference model
module tb_arm_register_file;
  import arm_rf_pkg::*;
  logic clk, reset, pc_load, pc_inc, wr_err;
  logic [15:0] wr_en;
  logic [31:0] wr_data, pc_data, rd_data_a, rd_data_b, rd_data_c, pc_out;
  reg_sel_t rd_addr_a, rd_addr_b, rd_addr_c;
  int checks, errors;
  logic [31:0] m [15];
  logic [31:0] mpc;
  logic merr, valid;

  arm_register_file #(.DATA_WIDTH(32), .PC_RESET(32'h100)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .pc_load(pc_load), .pc_data(pc_data), .pc_inc(pc_inc),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .pc_out(pc_out), .wr_err(wr_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rexp(input logic [3:0] a);
    return a == 4'd15 ? mpc + 32'd8 : m[a];
  endfunction

  task automatic model_edge();
    int n;
    n = $countones(wr_en);
    if (reset) begin
      foreach (m[k]) m[k] = 0;
      mpc = 32'h100;
      merr = 0;
      valid = 1;
    end else begin
      for (int k = 0; k < 15; k++) if (n == 1 && wr_en[k]) m[k] = wr_data;
      if (pc_load) mpc = pc_data;
      else if (n == 1 && wr_en[15]) mpc = wr_data;
      else if (pc_inc) mpc = mpc + 32'd4;
      if (n > 1) merr = 1;
    end
  endtask

  task automatic drive(input logic rs, input logic [15:0] we, input logic [31:0] wd,
                       input logic pl, input logic [31:0] pd, input logic pi,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    reset = rs; wr_en = we; wr_data = wd; pc_load = pl; pc_data = pd; pc_inc = pi;
    rd_addr_a = a; rd_addr_b = b; rd_addr_c = c;
    #1;
    if (valid) begin
      chk("rd_a", rd_data_a, rexp(a));
      chk("rd_b", rd_data_b, rexp(b));
      chk("rd_c", rd_data_c, rexp(c));
      chk("pc_out", pc_out, mpc);
      chk("wr_err", {31'd0, wr_err}, {31'd0, merr});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] we;
    checks = 0; errors = 0; valid = 0; merr = 0; mpc = 0;
    foreach (m[k]) m[k] = 0;
    reset = 0; wr_en = 0; wr_data = 0; pc_load = 0; pc_data = 0; pc_inc = 0;
    rd_addr_a = 0; rd_addr_b = 0; rd_addr_c = 0;
    @(negedge clk);
    drive(1, 16'h0, 32'h0, 0, 32'h0, 0, 4'd15, 4'd3, 4'd0);
    #1;
    chk("reset_pc", pc_out, 32'h100);
    chk("reset_r15", rd_data_a, 32'h108);
    chk("reset_r3", rd_data_b, 32'h0);
    chk("reset_err", {31'd0, wr_err}, 32'd0);
    drive(0, 16'h0008, 32'hDEAD_BEEF, 0, 32'h0, 0, 4'd3, 4'd3, 4'd3);
    #1;
    chk("write_r3_a", rd_data_a, 32'hDEAD_BEEF);
    chk("write_r3_c", rd_data_c, 32'hDEAD_BEEF);
    drive(0, 16'h8000, 32'h3000, 1, 32'h2000, 1, 4'd3, 4'd2, 4'd15);
    #1;
    chk("pc_priority", pc_out, 32'h2000);
    drive(0, 16'h0, 32'h0, 0, 32'h0, 1, 4'd15, 4'd4, 4'd5);
    #1;
    chk("pc_inc", pc_out, 32'h2004);
    drive(0, 16'h8000, 32'h5000, 0, 32'h0, 1, 4'd15, 4'd1, 4'd2);
    #1;
    chk("wr15_over_inc", pc_out, 32'h5000);
    drive(0, 16'h0, 32'h0, 1, 32'hFFFF_FFFC, 0, 4'd15, 4'd15, 4'd15);
    #1;
    chk("wrap_read", rd_data_a, 32'h4);
    drive(0, 16'h0, 32'h0, 0, 32'h0, 1, 4'd15, 4'd0, 4'd1);
    #1;
    chk("wrap_pc", pc_out, 32'h0);
    drive(0, 16'h0002, 32'h11, 0, 32'h0, 0, 4'd1, 4'd2, 4'd0);
    drive(0, 16'h0006, 32'h55, 0, 32'h0, 1, 4'd1, 4'd2, 4'd0);
    #1;
    chk("multi_r1", rd_data_a, 32'h11);
    chk("multi_r2", rd_data_b, 32'h0);
    chk("multi_err", {31'd0, wr_err}, 32'd1);
    drive(0, 16'h0020, 32'h77, 0, 32'h0, 0, 4'd5, 4'd1, 4'd2);
    #1;
    chk("err_sticky", {31'd0, wr_err}, 32'd1);
    chk("r5_after_err", rd_data_a, 32'h77);
    drive(1, 16'h0010, 32'hAA, 0, 32'h0, 0, 4'd4, 4'd5, 4'd15);
    #1;
    chk("rst_mid_r4", rd_data_a, 32'h0);
    chk("rst_clears_err", {31'd0, wr_err}, 32'd0);
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: we = 16'h0;
        3: we = 16'(($urandom & 32'hFFFF) | 32'h3);
        default: we = 16'h1 << $urandom_range(0, 15);
      endcase
      drive($urandom_range(0, 49) == 0, we, $urandom, $urandom_range(0, 7) == 0,
            $urandom, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    drive(0, 16'h0, 32'h0, 0, 32'h0, 0, 4'd15, 4'd7, 4'd14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
